// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM: counting modes and counter direction.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: registered compare of the shared counter against this channel's
// duty, with polarity inversion; parks at the inactive level while disabled.
module pwm_ch
  import pwm_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_cnt,
  input  logic [DW-1:0] i_duty,
  input  logic          i_pol,
  output logic          o_pwm
);

  logic w_level;
  logic r_pwm;

  always_comb begin
    w_level = i_pol;
    if (i_en) begin
      w_level = (i_cnt < i_duty) ^ i_pol;
    end else begin
      w_level = i_pol;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_level;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and edge/center-aligned counter with a
// shadowed configuration that only switches at period boundaries (or while idle).
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int PSW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [PSW-1:0]    prescale,
  input  logic [DW-1:0]     period,
  input  logic [NCH*DW-1:0] duty,
  input  logic [NCH-1:0]    pol,
  input  logic              load,
  output logic [NCH-1:0]    pwm,
  output logic [DW-1:0]     cnt,
  output logic              period_end,
  output logic              load_ack
);

  localparam logic [DW-1:0]  CNT_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [PSW-1:0] PSC_ONE = {{(PSW-1){1'b0}}, 1'b1};

  logic              r_pend_vld;
  logic              r_pend_mode, r_act_mode;
  logic [PSW-1:0]    r_pend_psc, r_act_psc, r_psc;
  logic [DW-1:0]     r_pend_per, r_act_per, r_cnt;
  logic [NCH*DW-1:0] r_pend_duty, r_act_duty;
  logic [NCH-1:0]    r_pend_pol, r_act_pol;
  dir_e              r_dir;
  logic              r_pe, r_ack;

  logic              w_tick, w_bnd, w_apply, w_use_in;
  logic [DW-1:0]     w_cnt_nxt;
  dir_e              w_dir_nxt;
  logic              w_src_mode;
  logic [PSW-1:0]    w_src_psc;
  logic [DW-1:0]     w_src_per;
  logic [NCH*DW-1:0] w_src_duty;
  logic [NCH-1:0]    w_src_pol;

  assign w_tick   = en && (r_psc == r_act_psc);
  assign w_bnd    = w_tick && (w_cnt_nxt == '0);
  assign w_apply  = en ? (w_bnd && (load || r_pend_vld)) : r_pend_vld;
  assign w_use_in = en && load;

  // Counter step; >= guards keep a held count above a newly shrunk top in range.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (r_act_per == '0) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (r_act_mode == MODE_EDGE) begin
      w_cnt_nxt = (r_cnt >= r_act_per) ? '0 : (r_cnt + CNT_ONE);
      w_dir_nxt = DIR_UP;
    end else if ((r_dir == DIR_UP) && (r_cnt < r_act_per)) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
      w_dir_nxt = DIR_UP;
    end else if (r_cnt == '0) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else begin
      w_cnt_nxt = r_cnt - CNT_ONE;
      w_dir_nxt = (r_cnt == CNT_ONE) ? DIR_UP : DIR_DOWN;
    end
  end

  always_comb begin
    w_src_mode = r_pend_mode;
    w_src_psc  = r_pend_psc;
    w_src_per  = r_pend_per;
    w_src_duty = r_pend_duty;
    w_src_pol  = r_pend_pol;
    if (w_use_in) begin
      w_src_mode = mode;
      w_src_psc  = prescale;
      w_src_per  = period;
      w_src_duty = duty;
      w_src_pol  = pol;
    end else begin
      w_src_mode = r_pend_mode;
      w_src_psc  = r_pend_psc;
      w_src_per  = r_pend_per;
      w_src_duty = r_pend_duty;
      w_src_pol  = r_pend_pol;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= '0;
      r_cnt <= '0;
      r_dir <= DIR_UP;
      r_pe  <= 1'b0;
    end else begin
      if (!en || w_tick) begin
        r_psc <= '0;
      end else begin
        r_psc <= r_psc + PSC_ONE;
      end
      if (w_apply && (w_src_mode != r_act_mode)) begin
        r_cnt <= '0;
        r_dir <= DIR_UP;
      end else if (w_tick) begin
        r_cnt <= w_cnt_nxt;
        r_dir <= w_dir_nxt;
      end else begin
        r_cnt <= r_cnt;
        r_dir <= r_dir;
      end
      r_pe <= w_bnd;
    end
  end

  // Shadow registers: a load at a boundary bypasses the pending set entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_mode <= MODE_EDGE;
      r_pend_psc  <= '0;
      r_pend_per  <= '0;
      r_pend_duty <= '0;
      r_pend_pol  <= '0;
      r_act_mode  <= MODE_EDGE;
      r_act_psc   <= '0;
      r_act_per   <= '0;
      r_act_duty  <= '0;
      r_act_pol   <= '0;
      r_ack       <= 1'b0;
    end else begin
      if (load) begin
        r_pend_mode <= mode;
        r_pend_psc  <= prescale;
        r_pend_per  <= period;
        r_pend_duty <= duty;
        r_pend_pol  <= pol;
      end
      if (load && !(w_apply && en)) begin
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end else begin
        r_pend_vld <= r_pend_vld;
      end
      if (w_apply) begin
        r_act_mode <= w_src_mode;
        r_act_psc  <= w_src_psc;
        r_act_per  <= w_src_per;
        r_act_duty <= w_src_duty;
        r_act_pol  <= w_src_pol;
      end
      r_ack <= w_apply;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_ch #(.DW(DW)) u_ch (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (en),
      .i_cnt   (r_cnt),
      .i_duty  (r_act_duty[g*DW +: DW]),
      .i_pol   (r_act_pol[g]),
      .o_pwm   (pwm[g])
    );
  end

  assign cnt        = r_cnt;
  assign period_end = r_pe;
  assign load_ack   = r_ack;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus pushes per-cycle expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_pwm_multi;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int PSW = 8;

  logic              clk = 1'b0;
  logic              rst_n, en, mode, load;
  logic [PSW-1:0]    prescale;
  logic [DW-1:0]     period;
  logic [NCH*DW-1:0] duty;
  logic [NCH-1:0]    pol;
  logic [NCH-1:0]    pwm;
  logic [DW-1:0]     cnt;
  logic              period_end, load_ack;

  pwm_multi #(.DW(DW), .NCH(NCH), .PSW(PSW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .prescale(prescale),
    .period(period), .duty(duty), .pol(pol), .load(load),
    .pwm(pwm), .cnt(cnt), .period_end(period_end), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           at;
    string        nm;
    logic [3:0]   mask;
    logic [DW-1:0] cnt;
    logic [3:0]   pwm;
    logic         pe;
    logic         ack;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.at != cyc) begin
        n_err++;
        $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", e.nm, e.at, cyc);
      end else if ((e.mask[0] && cnt !== e.cnt) || (e.mask[1] && pwm !== e.pwm) ||
                   (e.mask[2] && period_end !== e.pe) || (e.mask[3] && load_ack !== e.ack)) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got cnt=%0d pwm=%b pe=%b ack=%b, want cnt=%0d pwm=%b pe=%b ack=%b",
                 e.nm, cyc, cnt, pwm, period_end, load_ack, e.cnt, e.pwm, e.pe, e.ack);
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] m, input int c,
                      input logic [3:0] p, input logic pe, input logic ack);
    exp_t e;
    e.at = cyc; e.nm = nm; e.mask = m; e.cnt = c[DW-1:0];
    e.pwm = p; e.pe = pe; e.ack = ack;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*DW-1:0] pack(input int d3, input int d2, input int d1, input int d0);
    logic [NCH*DW-1:0] v;
    v = {d3[DW-1:0], d2[DW-1:0], d1[DW-1:0], d0[DW-1:0]};
    return v;
  endfunction

  function automatic logic [3:0] exp_pwm(input int c, input int d3, input int d2,
                                         input int d1, input int d0, input logic [3:0] po);
    logic [3:0] v;
    v = {c < d3, c < d2, c < d1, c < d0};
    return v ^ po;
  endfunction

  // Center-aligned tick sequence for top 4: 0,1,2,3,4,3,2,1 repeating.
  function automatic int cseq(input int i);
    int r;
    r = i % 8;
    return (r <= 4) ? r : (8 - r);
  endfunction

  task automatic drive_cfg(input logic m, input int ps, input int per,
                           input logic [NCH*DW-1:0] du, input logic [NCH-1:0] po);
    mode = m; prescale = ps[PSW-1:0]; period = per[DW-1:0]; duty = du; pol = po;
  endtask

  initial begin
    int d1;
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    drive_cfg(1'b0, 0, 0, pack(0, 0, 0, 0), 4'b0000);
    repeat (3) begin step(); push("reset", 4'hF, 0, 4'b0000, 1'b0, 1'b0); end
    rst_n = 1'b1;
    step(); push("idle", 4'hF, 0, 4'b0000, 1'b0, 1'b0);

    // Edge mode, top 9, duties 0/3/9/10 on channels 0..3, configured while idle.
    drive_cfg(1'b0, 0, 9, pack(10, 9, 3, 0), 4'b0000); load = 1'b1;
    step(); load = 1'b0; push("idle_cap", 4'hF, 0, 4'b0000, 1'b0, 1'b0);
    step(); push("idle_ack", 4'hF, 0, 4'b0000, 1'b0, 1'b1);
    en = 1'b1;
    for (int k = 1; k <= 74; k++) begin
      load = 1'b0;
      if (k == 34) begin duty = pack(10, 9, 7, 0); load = 1'b1; end
      else if (k == 44) begin duty = pack(10, 9, 5, 0); load = 1'b1; end
      else if (k == 46) begin duty = pack(10, 9, 2, 0); load = 1'b1; end
      else if (k == 60) begin duty = pack(10, 9, 8, 0); load = 1'b1; end
      else if (k == 62) begin pol = 4'b1010; load = 1'b1; end
      step();
      d1 = (k <= 40) ? 3 : (k <= 50) ? 7 : (k <= 60) ? 2 : 8;
      push("edge_run", 4'hF, k % 10,
           exp_pwm((k - 1) % 10, 10, 9, d1, 0, (k <= 70) ? 4'b0000 : 4'b1010),
           (k % 10) == 0, (k == 40) || (k == 50) || (k == 60) || (k == 70));
    end
    load = 1'b0;

    // Disable mid-period: outputs park at polarity, count holds at 4.
    en = 1'b0;
    for (int k = 75; k <= 77; k++) begin
      step(); push("en_low", 4'hF, 4, 4'b1010, 1'b0, 1'b0);
    end
    en = 1'b1;
    for (int ee = 75; ee <= 89; ee++) begin
      step();
      push("en_resume", 4'hF, ee % 10, exp_pwm((ee - 1) % 10, 10, 9, 8, 0, 4'b1010),
           (ee % 10) == 0, 1'b0);
    end

    // Center mode, top 4, prescale 1; mode change restarts the count at 0.
    en = 1'b0;
    step(); push("center_pre", 4'hF, 9, 4'b1010, 1'b0, 1'b0);
    drive_cfg(1'b1, 1, 4, pack(0, 5, 4, 2), 4'b0000); load = 1'b1;
    step(); load = 1'b0; push("center_cap", 4'hF, 9, 4'b1010, 1'b0, 1'b0);
    step(); push("center_ack", 4'hF, 0, 4'b1010, 1'b0, 1'b1);
    en = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      push("center_run", 4'hF, cseq(j / 2), exp_pwm(cseq((j - 1) / 2), 0, 5, 4, 2, 4'b0000),
           (j % 16) == 0, 1'b0);
    end

    // Top 0: count pinned at 0 and every tick is a boundary.
    en = 1'b0;
    step(); push("p0_pre", 4'hF, 4, 4'b0000, 1'b0, 1'b0);
    drive_cfg(1'b0, 0, 0, pack(3, 0, 1, 0), 4'b0000); load = 1'b1;
    step(); load = 1'b0; push("p0_cap", 4'hF, 4, 4'b0000, 1'b0, 1'b0);
    step(); push("p0_ack", 4'hF, 0, 4'b0000, 1'b0, 1'b1);
    en = 1'b1;
    repeat (6) begin step(); push("p0_run", 4'hF, 0, 4'b1010, 1'b1, 1'b0); end

    // Load on a boundary applies at once; then a pending load is lost to reset.
    drive_cfg(1'b0, 0, 9, pack(10, 9, 3, 0), 4'b0000); load = 1'b1;
    step(); load = 1'b0; push("p9_ack", 4'hF, 0, 4'b1010, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(); push("p9_run", 4'hF, k, exp_pwm(k - 1, 10, 9, 3, 0, 4'b0000), 1'b0, 1'b0);
    end
    pol = 4'b1111; load = 1'b1;
    step(); load = 1'b0; push("pend_cap", 4'hF, 5, exp_pwm(4, 10, 9, 3, 0, 4'b0000), 1'b0, 1'b0);
    step();
    #1; rst_n = 1'b0;
    push("async_rst", 4'hF, 0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk); #2; rst_n = 1'b1;
    repeat (4) begin step(); push("post_rst", 4'hF, 0, 4'b0000, 1'b1, 1'b0); end

    en = 1'b0;
    repeat (2) step();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
